trap_ctrl: RTL and testbench

//  Sequences machine-mode trap entry (ECALL, EBREAK, illegal instruction) and MRET return for the RV32I core.

---
 rtl/trap_if.sv | 32 +++
 rtl/trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_trap_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/trap_if.sv
// rtl/trap_if.sv - exception request, CSR access and PC redirect signals between execute stage and trap_ctrl
interface trap_if;
    logic        exc_ecall;
    logic        exc_ebreak;
    logic        exc_illegal;
    logic        mret_req;
    logic [31:0] reg_pc_val;
    logic [31:0] ins_word;
    logic        csr_w_op;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_val;
    logic [11:0] csr_r_addr;
    logic [31:0] csr_r_val;
    logic        reg_pc_w_op;
    logic [31:0] reg_pc_w_val;
    logic        busy;
    logic        trap_ack;

    modport master (
        output exc_ecall, exc_ebreak, exc_illegal, mret_req,
        output reg_pc_val, ins_word,
        output csr_w_op, csr_w_addr, csr_w_val, csr_r_addr,
        input  csr_r_val, reg_pc_w_op, reg_pc_w_val, busy, trap_ack
    );

    modport slave (
        input  exc_ecall, exc_ebreak, exc_illegal, mret_req,
        input  reg_pc_val, ins_word,
        input  csr_w_op, csr_w_addr, csr_w_val, csr_r_addr,
        output csr_r_val, reg_pc_w_op, reg_pc_w_val, busy, trap_ack
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap entry / MRET sequencer owning the trap CSRs and the PC redirect
module trap_ctrl #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic   clk,
    input  logic   rst,
    trap_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_JUMP = 3'd2,
        ST_RET  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_ECALL   = 2'd0,
        KIND_EBREAK  = 2'd1,
        KIND_ILLEGAL = 2'd2,
        KIND_MRET    = 2'd3
    } kind_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [31:0] MTVEC_RST = {RESET_MTVEC[31:2], 2'b00};

    state_t      state_q,  state_d;
    kind_t       kind_q,   kind_d;
    logic [31:0] pc_lat_q, pc_lat_d;
    logic [31:0] ins_lat_q, ins_lat_d;
    logic [31:0] mtvec_q,  mtvec_d;
    logic [31:0] mepc_q,   mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q,  mtval_d;
    logic        mie_q,    mie_d;
    logic        mpie_q,   mpie_d;

    logic        req_any;
    logic [31:0] mstatus_rd;

    assign req_any    = bus.exc_ecall | bus.exc_ebreak | bus.exc_illegal | bus.mret_req;
    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_ECALL;
            pc_lat_q  <= 32'd0;
            ins_lat_q <= 32'd0;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= 32'd0;
            mcause_q  <= 32'd0;
            mtval_q   <= 32'd0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            pc_lat_q  <= pc_lat_d;
            ins_lat_q <= ins_lat_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mtval_q   <= mtval_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pc_lat_d  = pc_lat_q;
        ins_lat_d = ins_lat_q;
        mtvec_d   = mtvec_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        mie_d     = mie_q;
        mpie_d    = mpie_q;

        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    pc_lat_d  = bus.reg_pc_val;
                    ins_lat_d = bus.ins_word;
                    if (bus.exc_illegal) begin
                        kind_d  = KIND_ILLEGAL;
                        state_d = ST_SAVE;
                    end else if (bus.exc_ebreak) begin
                        kind_d  = KIND_EBREAK;
                        state_d = ST_SAVE;
                    end else if (bus.exc_ecall) begin
                        kind_d  = KIND_ECALL;
                        state_d = ST_SAVE;
                    end else begin
                        kind_d  = KIND_MRET;
                        state_d = ST_RET;
                    end
                end else if (bus.csr_w_op) begin
                    // A pending request in the same cycle takes this branch's place, so the write is lost.
                    case (bus.csr_w_addr)
                        ADDR_MSTATUS: begin
                            mie_d  = bus.csr_w_val[3];
                            mpie_d = bus.csr_w_val[7];
                        end
                        ADDR_MTVEC:  mtvec_d  = {bus.csr_w_val[31:2], 2'b00};
                        ADDR_MEPC:   mepc_d   = {bus.csr_w_val[31:2], 2'b00};
                        ADDR_MCAUSE: mcause_d = bus.csr_w_val;
                        ADDR_MTVAL:  mtval_d  = bus.csr_w_val;
                        default: ;
                    endcase
                end
            end
            ST_SAVE: begin
                mepc_d = {pc_lat_q[31:2], 2'b00};
                case (kind_q)
                    KIND_ILLEGAL: begin
                        mcause_d = 32'd2;
                        mtval_d  = ins_lat_q;
                    end
                    KIND_EBREAK: begin
                        mcause_d = 32'd3;
                        mtval_d  = pc_lat_q;
                    end
                    default: begin
                        mcause_d = 32'd11;
                        mtval_d  = 32'd0;
                    end
                endcase
                mpie_d  = mie_q;
                mie_d   = 1'b0;
                state_d = ST_JUMP;
            end
            ST_JUMP: state_d = ST_ACK;
            ST_RET: begin
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are masked by rst so a reset landing in JUMP/RET/ACK never escapes as a redirect or ack.
    always_comb begin
        bus.reg_pc_w_op  = 1'b0;
        bus.reg_pc_w_val = 32'd0;
        bus.trap_ack     = 1'b0;
        bus.busy         = (state_q != ST_IDLE);
        if (!rst) begin
            if (state_q == ST_JUMP) begin
                bus.reg_pc_w_op  = 1'b1;
                bus.reg_pc_w_val = {mtvec_q[31:2], 2'b00};
            end else if (state_q == ST_RET) begin
                bus.reg_pc_w_op  = 1'b1;
                bus.reg_pc_w_val = mepc_q;
            end
            bus.trap_ack = (state_q == ST_ACK);
        end
    end

    always_comb begin
        bus.csr_r_val = 32'd0;
        case (bus.csr_r_addr)
            ADDR_MSTATUS: bus.csr_r_val = mstatus_rd;
            ADDR_MTVEC:   bus.csr_r_val = mtvec_q;
            ADDR_MEPC:    bus.csr_r_val = mepc_q;
            ADDR_MCAUSE:  bus.csr_r_val = mcause_q;
            ADDR_MTVAL:   bus.csr_r_val = mtval_q;
            default:      bus.csr_r_val = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    trap_if bus ();

    trap_ctrl #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] val);
        bus.csr_r_addr = addr;
        #1;
        val = bus.csr_r_val;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] val);
        bus.csr_w_op   = 1'b1;
        bus.csr_w_addr = addr;
        bus.csr_w_val  = val;
        step();
        bus.csr_w_op   = 1'b0;
    endtask

    task automatic clear_reqs();
        bus.exc_ecall   = 1'b0;
        bus.exc_ebreak  = 1'b0;
        bus.exc_illegal = 1'b0;
        bus.mret_req    = 1'b0;
    endtask

    // Requests are already driven; i counts cycles after the sampling edge N.
    task automatic run_seq(output int busy_n, output int pulse_n, output logic [31:0] pc_seen,
                           output int pulse_at, output int ack_at);
        busy_n = 0; pulse_n = 0; pc_seen = 32'hDEAD_BEEF; pulse_at = -1; ack_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus.busy) busy_n++;
            if (bus.reg_pc_w_op) begin
                pulse_n++;
                pulse_at = i;
                pc_seen  = bus.reg_pc_w_val;
            end
            if (bus.trap_ack) begin
                ack_at = i;
                clear_reqs();
            end
            if (!bus.busy) break;
        end
        clear_reqs();
    endtask

    logic [31:0] v;
    logic [31:0] pcv;
    int          bn, pn, pat, aat;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clear_reqs();
        bus.reg_pc_val = 32'd0;
        bus.ins_word   = 32'd0;
        bus.csr_w_op   = 1'b0;
        bus.csr_w_addr = 12'd0;
        bus.csr_w_val  = 32'd0;
        bus.csr_r_addr = 12'd0;
        step();
        step();
        rst = 1'b0;
        #1;

        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pcw_op", {31'd0, bus.reg_pc_w_op}, 32'd0);
        chk("rst_pcw_val", bus.reg_pc_w_val, 32'd0);
        chk("rst_ack", {31'd0, bus.trap_ack}, 32'd0);
        rd(12'h305, v); chk("rst_mtvec", v, 32'h0000_0100);
        rd(12'h300, v); chk("rst_mstatus", v, 32'h0000_1800);
        rd(12'h341, v); chk("rst_mepc", v, 32'd0);

        // ecall from pc 0x40
        bus.reg_pc_val = 32'h0000_0040;
        bus.exc_ecall  = 1'b1;
        run_seq(bn, pn, pcv, pat, aat);
        chk("ecall_pc", pcv, 32'h0000_0100);
        chk("ecall_pulse_at", pat, 2);
        chk("ecall_ack_at", aat, 3);
        chk("ecall_busy_n", bn, 3);
        rd(12'h341, v); chk("ecall_mepc", v, 32'h0000_0040);
        rd(12'h342, v); chk("ecall_mcause", v, 32'd11);
        rd(12'h343, v); chk("ecall_mtval", v, 32'd0);

        // illegal + ecall together: illegal wins, one trap only
        bus.reg_pc_val  = 32'h0000_0080;
        bus.ins_word    = 32'hFFFF_FFFF;
        bus.exc_illegal = 1'b1;
        bus.exc_ecall   = 1'b1;
        run_seq(bn, pn, pcv, pat, aat);
        chk("ill_busy_n", bn, 3);
        chk("ill_pulses", pn, 1);
        rd(12'h342, v); chk("ill_mcause", v, 32'd2);
        rd(12'h343, v); chk("ill_mtval", v, 32'hFFFF_FFFF);
        rd(12'h341, v); chk("ill_mepc", v, 32'h0000_0080);

        // reprogram mtvec and enable MIE, then ebreak
        wr(12'h305, 32'h0000_2003);
        wr(12'h300, 32'h0000_0008);
        rd(12'h305, v); chk("wr_mtvec", v, 32'h0000_2000);
        rd(12'h300, v); chk("wr_mstatus", v, 32'h0000_1808);
        bus.reg_pc_val = 32'h0000_0010;
        bus.exc_ebreak = 1'b1;
        run_seq(bn, pn, pcv, pat, aat);
        chk("ebrk_pc", pcv, 32'h0000_2000);
        rd(12'h342, v); chk("ebrk_mcause", v, 32'd3);
        rd(12'h343, v); chk("ebrk_mtval", v, 32'h0000_0010);
        rd(12'h300, v); chk("ebrk_mstatus", v, 32'h0000_1880);

        // mret back to 0x44 with MPIE=1
        wr(12'h341, 32'h0000_0047);
        rd(12'h341, v); chk("wr_mepc_mask", v, 32'h0000_0044);
        bus.mret_req = 1'b1;
        run_seq(bn, pn, pcv, pat, aat);
        chk("mret_pc", pcv, 32'h0000_0044);
        chk("mret_pulse_at", pat, 1);
        chk("mret_ack_at", aat, 2);
        chk("mret_busy_n", bn, 2);
        rd(12'h300, v); chk("mret_mstatus", v, 32'h0000_1888);

        // unmapped write dropped, mtval takes all 32 bits
        wr(12'h7C0, 32'h1234_5678);
        rd(12'h7C0, v); chk("unmapped_rd", v, 32'd0);
        wr(12'h343, 32'hA5A5_A5A7);
        rd(12'h343, v); chk("wr_mtval", v, 32'hA5A5_A5A7);

        // csr write concurrent with ecall is dropped
        bus.csr_w_op   = 1'b1;
        bus.csr_w_addr = 12'h341;
        bus.csr_w_val  = 32'h0000_1234;
        bus.reg_pc_val = 32'h0000_0060;
        bus.exc_ecall  = 1'b1;
        step();
        bus.csr_w_op   = 1'b0;
        chk("conc_busy", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < 6 && bus.busy; i++) begin
            if (bus.trap_ack) clear_reqs();
            step();
        end
        clear_reqs();
        chk("conc_idle", {31'd0, bus.busy}, 32'd0);
        rd(12'h341, v); chk("conc_mepc", v, 32'h0000_0060);

        // reset while in JUMP
        bus.reg_pc_val = 32'h0000_0070;
        bus.exc_ecall  = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rstj_pcw_op", {31'd0, bus.reg_pc_w_op}, 32'd0);
        chk("rstj_ack", {31'd0, bus.trap_ack}, 32'd0);
        clear_reqs();
        step();
        rst = 1'b0;
        #1;
        chk("rstj_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstj_ack2", {31'd0, bus.trap_ack}, 32'd0);
        rd(12'h305, v); chk("rstj_mtvec", v, 32'h0000_0100);
        rd(12'h341, v); chk("rstj_mepc", v, 32'd0);
        step();
        chk("rstj_stays_idle", {31'd0, bus.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
